// File: rtl/mm_pkg.sv
// Shared types and helpers for the Mastermind round sequencer.
// A code word packs four 3-bit colours: [2:0] is position 0 and [11:9] is position 3.
package mm_pkg;

   localparam int POS_W   = 3;
   localparam int NUM_POS = 4;
   localparam int CODE_W  = POS_W * NUM_POS;

   localparam logic [POS_W-1:0] COLOUR_EMPTY = 3'd0;
   localparam logic [POS_W-1:0] COLOUR_MIN   = 3'd1;
   localparam logic [POS_W-1:0] COLOUR_MAX   = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ENTRY       = 3'd1,
      ST_SCORE_EXACT = 3'd2,
      ST_SCORE_COLOR = 3'd3,
      ST_HOLD        = 3'd4,
      ST_WON         = 3'd5,
      ST_LOST        = 3'd6
   } mm_state_e;

   // Colour at position idx of a packed code word.
   function automatic logic [POS_W-1:0] get_field(input logic [CODE_W-1:0] code,
                                                  input logic [1:0]        idx);
      return code[int'(idx)*POS_W +: POS_W];
   endfunction

   // Next colour for a tapped peg: empty or 6 both wrap to 1.
   function automatic logic [POS_W-1:0] next_colour(input logic [POS_W-1:0] f);
      return (f >= COLOUR_MAX) ? COLOUR_MIN : f + 3'd1;
   endfunction

   // Number of positions holding colour c (0..4).
   function automatic logic [2:0] count_colour(input logic [CODE_W-1:0] code,
                                               input logic [POS_W-1:0]  c);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < NUM_POS; i++)
         if (code[i*POS_W +: POS_W] == c) n = n + 3'd1;
      return n;
   endfunction

   // True when no position is empty.
   function automatic logic code_complete(input logic [CODE_W-1:0] code);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NUM_POS; i++)
         if (code[i*POS_W +: POS_W] == COLOUR_EMPTY) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/mm_round_ctrl_if.sv
// Front-end / display bundle of the round sequencer.
// master: touch front-end + display side; slave: the sequencer.
interface mm_round_ctrl_if;
   import mm_pkg::*;

   logic              secret_valid;
   logic [CODE_W-1:0] secret;
   logic              tap_valid;
   logic [2:0]        tap_col;
   logic              new_game;

   logic [CODE_W-1:0] guess;
   logic [2:0]        row;
   logic [2:0]        black;
   logic [2:0]        white;
   logic              score_valid;
   logic              commit_reject;
   logic              busy;
   logic              win;
   logic              lose;

   modport master (
      output secret_valid, secret, tap_valid, tap_col, new_game,
      input  guess, row, black, white, score_valid, commit_reject, busy, win, lose
   );

   modport slave (
      input  secret_valid, secret, tap_valid, tap_col, new_game,
      output guess, row, black, white, score_valid, commit_reject, busy, win, lose
   );

endinterface

// File: rtl/mm_peg_scorer.sv
// Multi-cycle peg scorer: four exact-match cycles (position 0..3) followed by
// six colour cycles (colour 1..6). white is resolved on the last colour cycle
// as (sum of per-colour minimum counts) - black, which can never underflow.
module mm_peg_scorer
   import mm_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start_i,
   input  logic              clear_i,
   input  logic [CODE_W-1:0] guess_i,
   input  logic [CODE_W-1:0] secret_i,
   output logic [2:0]        black_o,
   output logic [2:0]        white_o,
   output logic              exact_done_o,
   output logic              done_o
);

   logic       run_q, run_d;
   logic       colour_q, colour_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] black_q, black_d;
   logic [2:0] white_q, white_d;
   logic [2:0] acc_q, acc_d;
   logic [2:0] g_cnt, s_cnt, m_cnt;

   assign g_cnt = count_colour(guess_i, cnt_q);
   assign s_cnt = count_colour(secret_i, cnt_q);
   assign m_cnt = (g_cnt < s_cnt) ? g_cnt : s_cnt;

   // Scorer registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         run_q    <= 1'b0;
         colour_q <= 1'b0;
         cnt_q    <= '0;
         black_q  <= '0;
         white_q  <= '0;
         acc_q    <= '0;
      end else begin
         run_q    <= run_d;
         colour_q <= colour_d;
         cnt_q    <= cnt_d;
         black_q  <= black_d;
         white_q  <= white_d;
         acc_q    <= acc_d;
      end
   end

   // Iterate positions, then colours; clear wins over start.
   always_comb begin
      run_d    = run_q;
      colour_d = colour_q;
      cnt_d    = cnt_q;
      black_d  = black_q;
      white_d  = white_q;
      acc_d    = acc_q;
      if (clear_i || start_i) begin
         run_d    = start_i && !clear_i;
         colour_d = 1'b0;
         cnt_d    = '0;
         black_d  = '0;
         white_d  = '0;
         acc_d    = '0;
      end else if (run_q && !colour_q) begin
         if (get_field(guess_i, cnt_q[1:0]) == get_field(secret_i, cnt_q[1:0]))
            black_d = black_q + 3'd1;
         if (cnt_q == 3'(NUM_POS - 1)) begin
            colour_d = 1'b1;
            cnt_d    = COLOUR_MIN;
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end else if (run_q) begin
         acc_d = acc_q + m_cnt;
         if (cnt_q == COLOUR_MAX) begin
            white_d  = acc_q + m_cnt - black_q;
            run_d    = 1'b0;
            colour_d = 1'b0;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   assign black_o      = black_q;
   assign white_o      = white_q;
   assign exact_done_o = run_q && !colour_q && (cnt_q == 3'(NUM_POS - 1));
   assign done_o       = run_q && colour_q && (cnt_q == COLOUR_MAX);

endmodule

// File: rtl/mm_round_ctrl.sv
// Mastermind round sequencer: owns the guess register, row counter and hold
// timer, and drives the peg scorer.
// Optional build macro MM_SECRET_REVEAL_EN adds the reveal output (latched
// secret while WON/LOST, zero otherwise).
//
// state          | meaning
// ---------------+-----------------------------------------------------
// ST_IDLE        | waiting for a secret
// ST_ENTRY       | column taps edit the guess, commit starts scoring
// ST_SCORE_EXACT | scorer compares positions 0..3 (4 cycles)
// ST_SCORE_COLOR | scorer sums colour overlaps 1..6 (6 cycles)
// ST_HOLD        | score displayed for HOLD_CYCLES
// ST_WON         | four exact matches; waits for new_game
// ST_LOST        | last row missed; waits for new_game
module mm_round_ctrl
   import mm_pkg::*;
#(
   parameter int NUM_ROWS    = 8,
   parameter int HOLD_CYCLES = 25000000
)(
   input  logic              clock,
   input  logic              reset,
   mm_round_ctrl_if.slave    bus
`ifdef MM_SECRET_REVEAL_EN
   ,
   output logic [CODE_W-1:0] reveal
`endif
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [2:0]        ROW_TOP   = 3'(NUM_ROWS - 1);

   mm_state_e         state_q, state_d;
   logic [CODE_W-1:0] guess_q, guess_d;
   logic [CODE_W-1:0] secret_q, secret_d;
   logic [2:0]        row_q, row_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              reject_q, reject_d;

   logic              tap_peg, tap_commit;
   logic              score_start, score_clear;
   logic              exact_done, score_done;
   logic [2:0]        black, white;

   assign tap_peg    = bus.tap_valid && !bus.tap_col[2];
   assign tap_commit = bus.tap_valid && (bus.tap_col == 3'd4);

   mm_peg_scorer u_scorer (
      .clock        (clock),
      .reset        (reset),
      .start_i      (score_start),
      .clear_i      (score_clear),
      .guess_i      (guess_q),
      .secret_i     (secret_q),
      .black_o      (black),
      .white_o      (white),
      .exact_done_o (exact_done),
      .done_o       (score_done)
   );

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         guess_q  <= '0;
         secret_q <= '0;
         row_q    <= ROW_TOP;
         hold_q   <= '0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         secret_q <= secret_d;
         row_q    <= row_d;
         hold_q   <= hold_d;
         reject_q <= reject_d;
      end
   end

   // Next state, guess editing, row advance and hold timer.
   always_comb begin
      state_d     = state_q;
      guess_d     = guess_q;
      secret_d    = secret_q;
      row_d       = row_q;
      hold_d      = hold_q;
      reject_d    = 1'b0;
      score_start = 1'b0;
      score_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.secret_valid) begin
               secret_d = bus.secret;
               state_d  = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            if (tap_peg) begin
               for (int k = 0; k < NUM_POS; k++)
                  if (bus.tap_col[1:0] == 2'(k))
                     guess_d[k*POS_W +: POS_W] = next_colour(guess_q[k*POS_W +: POS_W]);
            end else if (tap_commit) begin
               if (code_complete(guess_q)) begin
                  score_start = 1'b1;
                  state_d     = ST_SCORE_EXACT;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         ST_SCORE_EXACT: begin
            if (exact_done) state_d = ST_SCORE_COLOR;
         end
         ST_SCORE_COLOR: begin
            if (score_done) begin
               hold_d  = HOLD_LOAD;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_q == '0) begin
               if (black == 3'(NUM_POS)) begin
                  state_d = ST_WON;
               end else if (row_q == 3'd0) begin
                  state_d = ST_LOST;
               end else begin
                  row_d   = row_q - 3'd1;
                  guess_d = '0;
                  state_d = ST_ENTRY;
               end
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         ST_WON, ST_LOST: begin
            if (bus.new_game) begin
               row_d       = ROW_TOP;
               guess_d     = '0;
               score_clear = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status flags decoded from the current state.
   always_comb begin
      bus.score_valid = 1'b0;
      bus.busy        = 1'b0;
      bus.win         = 1'b0;
      bus.lose        = 1'b0;
      case (state_q)
         ST_SCORE_EXACT, ST_SCORE_COLOR: bus.busy = 1'b1;
         ST_HOLD: begin
            bus.busy        = 1'b1;
            bus.score_valid = 1'b1;
         end
         ST_WON: begin
            bus.score_valid = 1'b1;
            bus.win         = 1'b1;
         end
         ST_LOST: begin
            bus.score_valid = 1'b1;
            bus.lose        = 1'b1;
         end
         default: ;
      endcase
`ifdef MM_SECRET_REVEAL_EN
      reveal = (state_q == ST_WON || state_q == ST_LOST) ? secret_q : '0;
`endif
   end

   assign bus.guess         = guess_q;
   assign bus.row           = row_q;
   assign bus.black         = black;
   assign bus.white         = white;
   assign bus.commit_reject = reject_q;

endmodule

// File: tb/tb_mm_round_ctrl.sv
module tb_mm_round_ctrl;
   import mm_pkg::*;

   localparam int NUM_ROWS    = 2;
   localparam int HOLD_CYCLES = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;

   mm_round_ctrl_if bus ();
`ifdef MM_SECRET_REVEAL_EN
   logic [11:0] reveal;
`endif

   mm_round_ctrl #(.NUM_ROWS(NUM_ROWS), .HOLD_CYCLES(HOLD_CYCLES)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef MM_SECRET_REVEAL_EN
      ,
      .reveal(reveal)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0] black;
      logic [2:0] white;
      logic [2:0] row;
   } score_t;

   score_t exp_q[$];
   score_t exp_e;
   int     n_tests    = 0;
   int     n_fail     = 0;
   int     reject_cnt = 0;
   logic   sv_prev    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: counts reject pulses and scores each new result against the queue.
   always @(negedge clock) begin
      if (!reset) begin
         sv_prev = 1'b0;
      end else begin
         if (bus.commit_reject) reject_cnt++;
         if (bus.score_valid && !sv_prev) begin
            check("score_queued", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               exp_e = exp_q.pop_front();
               check("score_black", bus.black, exp_e.black);
               check("score_white", bus.white, exp_e.white);
               check("score_row",   bus.row,   exp_e.row);
            end
         end
         sv_prev = bus.score_valid;
      end
   end

   function automatic logic [11:0] pack(input int a0, input int a1, input int a2, input int a3);
      return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic tap(input logic [2:0] col);
      bus.tap_valid = 1'b1;
      bus.tap_col   = col;
      step(1);
      bus.tap_valid = 1'b0;
      bus.tap_col   = 3'd0;
   endtask

   task automatic enter(input int a0, input int a1, input int a2, input int a3);
      repeat (a0) tap(3'd0);
      repeat (a1) tap(3'd1);
      repeat (a2) tap(3'd2);
      repeat (a3) tap(3'd3);
   endtask

   task automatic load_secret(input logic [11:0] s);
      bus.secret_valid = 1'b1;
      bus.secret       = s;
      step(1);
      bus.secret_valid = 1'b0;
      bus.secret       = '0;
   endtask

   task automatic pulse_new_game();
      bus.new_game = 1'b1;
      step(1);
      bus.new_game = 1'b0;
   endtask

   task automatic push_score(input int b, input int w, input int r);
      score_t e;
      e.black = 3'(b);
      e.white = 3'(w);
      e.row   = 3'(r);
      exp_q.push_back(e);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_guess"},  bus.guess, 0);
      check({tag, "_row"},    bus.row, NUM_ROWS - 1);
      check({tag, "_black"},  bus.black, 0);
      check({tag, "_white"},  bus.white, 0);
      check({tag, "_flags"},  {bus.score_valid, bus.commit_reject, bus.busy, bus.win, bus.lose}, 0);
`ifdef MM_SECRET_REVEAL_EN
      check({tag, "_reveal"}, reveal, 0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      bus.secret_valid = 1'b0;
      bus.secret       = '0;
      bus.tap_valid    = 1'b0;
      bus.tap_col      = 3'd0;
      bus.new_game     = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
      check_reset_values("por");

      // Taps are ignored before a secret is loaded.
      tap(3'd0);
      check("idle_tap", bus.guess, 0);

      load_secret(pack(2, 6, 5, 2));

      // Column 1 walks 1..6 and wraps to 1.
      for (int i = 0; i < 7; i++) begin
         tap(3'd1);
         check("tap_wrap", bus.guess[5:3], (i % 6) + 1);
      end

      // Build (2,2,0,1) and commit with position 2 empty.
      tap(3'd1);
      enter(2, 0, 0, 1);
      check("guess_partial", bus.guess, pack(2, 2, 0, 1));
      r0 = reject_cnt;
      tap(3'd4);
      step(3);
      check("reject_once", reject_cnt - r0, 1);
      check("reject_state", {bus.busy, bus.score_valid}, 0);
      check("reject_guess", bus.guess, pack(2, 2, 0, 1));

      // Complete to (2,2,6,1) vs secret (2,6,5,2): black 1, white 2.
      enter(0, 0, 6, 0);
      check("guess_full", bus.guess, pack(2, 2, 6, 1));
      push_score(1, 2, 1);
      tap(3'd4);
      check("busy_start", bus.busy, 1);
      tap(3'd0);
      check("busy_tap", bus.guess, pack(2, 2, 6, 1));
      step(8);
      check("lat_n10_sv", bus.score_valid, 0);
      step(1);
      check("lat_n11_sv", {bus.score_valid, bus.busy}, 2'b11);
      step(HOLD_CYCLES);
      check("adv_busy", {bus.busy, bus.score_valid}, 0);
      check("adv_row", bus.row, 0);
      check("adv_guess", bus.guess, 0);
      check("adv_keep", {bus.black, bus.white}, {3'd1, 3'd2});

      // Exact guess on row 0: win with row unchanged.
      enter(2, 6, 5, 2);
      push_score(4, 0, 0);
      tap(3'd4);
      step(10 + HOLD_CYCLES);
      check("won_flags", {bus.win, bus.lose, bus.busy, bus.score_valid}, 4'b1001);
      check("won_row", bus.row, 0);
`ifdef MM_SECRET_REVEAL_EN
      check("won_reveal", reveal, pack(2, 6, 5, 2));
`endif
      tap(3'd0);
      check("won_tap", bus.guess, pack(2, 6, 5, 2));
      pulse_new_game();
      check_reset_values("newgame");

      // Two misses with two rows: lose.
      load_secret(pack(1, 2, 3, 4));
      enter(1, 1, 1, 1);
      push_score(1, 0, 1);
      tap(3'd4);
      pulse_new_game();
      step(9 + HOLD_CYCLES);
      check("miss1_row", bus.row, 0);
      check("miss1_flags", {bus.win, bus.lose, bus.busy}, 0);
      enter(4, 3, 2, 1);
      push_score(0, 4, 0);
      tap(3'd4);
      step(10 + HOLD_CYCLES);
      check("lost_flags", {bus.win, bus.lose, bus.score_valid}, 3'b011);
      check("lost_score", {bus.black, bus.white}, {3'd0, 3'd4});
      pulse_new_game();
      check_reset_values("lost_ng");
      tap(3'd0);
      check("lost_ng_idle", bus.guess, 0);

      // Reset during exact scoring discards everything.
      load_secret(pack(2, 6, 5, 2));
      enter(2, 6, 5, 2);
      tap(3'd4);
      step(2);
      check("pre_rst_black", bus.black, 2);
      reset = 1'b0;
      #1;
      check_reset_values("rst_async");
      step(1);
      reset = 1'b1;
      step(1);
      check_reset_values("rst_after");
      tap(3'd0);
      check("rst_idle", bus.guess, 0);

      step(2);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mm_round_ctrl.md
Name: mm_round_ctrl

Overview:
- Round sequencer for the Mastermind datapath; sits between the touch front-end and the display/LED logic.
- Takes decoded column taps and a commit request, owns the guess register and the row counter, and sequences a multi-cycle peg scorer.
- Holds each result for a fixed display time, then advances the row or ends the game (win/loss).

Parameters:
- NUM_ROWS, 8, number of guess rows; row index counts down from NUM_ROWS-1 to 0.
- HOLD_CYCLES, 25000000, cycles the score is held before the next row opens (minimum 1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- secret_valid  in  1  one-cycle pulse; secret is sampled while in IDLE
- secret  in  12  four 3-bit colour codes: [2:0]=pos0 … [11:9]=pos3, values 1..6
- tap_valid  in  1  one-cycle debounced tap strobe
- tap_col  in  3  0..3 = peg column, 4 = commit, 5..7 ignored
- new_game  in  1  pulse; honoured only in WON/LOST
- guess  out  12  current guess, same packing as secret; 0 = empty
- row  out  3  active row index
- black  out  3  exact matches, 0..4
- white  out  3  colour-only matches, 0..4
- score_valid  out  1  high throughout HOLD/WON/LOST
- commit_reject  out  1  one-cycle pulse: commit with any empty position
- busy  out  1  high in SCORE_EXACT, SCORE_COLOR, HOLD
- win  out  1  high in WON
- lose  out  1  high in LOST

Behaviour:
- Reset values: guess=0, row=NUM_ROWS-1, black=0, white=0, all flags 0, state=IDLE, internal secret register=0.
- States: IDLE, ENTRY, SCORE_EXACT, SCORE_COLOR, HOLD, WON, LOST.
- IDLE: on secret_valid, latch secret and go to ENTRY.
- ENTRY, tap on column k (0..3): field k increments; 6 and 0 both go to 1.
- ENTRY, commit tap:
  - If all four fields are nonzero: clear black/white, go to SCORE_EXACT with idx=0.
  - Otherwise: pulse commit_reject and stay in ENTRY.
- Taps are ignored in every state other than ENTRY.
- SCORE_EXACT: 4 cycles, idx 0..3; black += (guess[idx]==secret[idx]).
- SCORE_COLOR: 6 cycles, colour c=1..6.
  - acc += min(count of c in guess, count of c in secret).
  - On the last cycle, white = acc_final - black. No underflow is possible because acc_final >= black.
  - All counters are 3 bits wide; 4 is the maximum.
- Latency: commit accepted at cycle N → SCORE_EXACT N+1..N+4 → SCORE_COLOR N+5..N+10 → score_valid high at N+11.
- HOLD: counts HOLD_CYCLES, then:
  - black==4 → WON.
  - else row==0 → LOST.
  - else row-1, guess=0, go to ENTRY. black/white keep their values until the next commit.
- WON/LOST: outputs hold; new_game → IDLE with row=NUM_ROWS-1, guess=0, black=white=0.
- Simultaneous events: secret_valid outside IDLE is ignored. new_game outside WON/LOST is ignored.
- Reset asserted mid-scoring or mid-HOLD: immediate return to reset values; partial results are discarded.

Optional Feature:
- Macro MM_SECRET_REVEAL_EN.
- Defined: adds output reveal [11:0], equal to the latched secret in WON/LOST and 0 in all other states.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mm_pkg holds:
  - colour code constants: EMPTY=0, MIN=1, MAX=6;
  - POS_W=3, NUM_POS=4;
  - the state enum encoding.
- One sub-module, mm_peg_scorer: the SCORE_EXACT/SCORE_COLOR iterator and accumulators, with start/done handshake. The controller keeps the FSM, row counter, guess register and hold timer.

Test Plan:
- Secret fields (2,6,5,2); taps give guess fields (2,2,6,1); commit → at N+11: black=1, white=2, score_valid=1, busy low afterwards.
- Guess equals secret (2,6,5,2); commit → black=4, white=0; after HOLD_CYCLES (set to 4), win=1 and row unchanged.
- Guess with pos2=0, commit → commit_reject pulses once, state stays ENTRY, score_valid=0.
- Tap column 1 seven times from 0 → field goes 1,2,3,4,5,6,1; taps during busy leave guess unchanged.
- NUM_ROWS=2, two wrong commits → row 1→0 then lose=1; new_game → row=1, guess=0, state IDLE.
- Reset asserted at cycle N+3 of scoring → all outputs at reset values next cycle; with MM_SECRET_REVEAL_EN, reveal=0 there and equals secret in WON.
